// File: rtl/la_capture.sv
// Logic-analyser capture stage: circular sample buffer with masked-match trigger,
// programmable pre-trigger depth, and an oldest-first valid/ready readout.
module la_capture #(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  io_probe,
   input  logic              io_arm,
   input  logic              io_abort,
   input  logic [WIDTH-1:0]  io_trig_mask,
   input  logic [WIDTH-1:0]  io_trig_value,
   input  logic [ADDR_W-1:0] io_pretrig,
   output logic              io_out_valid,
   input  logic              io_out_ready,
   output logic [WIDTH-1:0]  io_out_data,
   output logic              io_out_last,
   output logic              io_done,
   output logic [1:0]        io_state
);
   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ARMED     = 2'd1;
   localparam logic [1:0] S_TRIGGERED = 2'd2;
   localparam logic [1:0] S_READOUT   = 2'd3;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] post_q, post_d;
   logic [ADDR_W-1:0] pretrig_q, pretrig_d;
   logic [ADDR_W:0]   filled_q, filled_d;
   logic              done_q, done_d;
   logic              hit, trig, we;
   logic [ADDR_W-1:0] post_ld;

   assign hit     = ((io_probe ^ io_trig_value) & io_trig_mask) == '0;
   // filled_q is the count before this cycle's write, so the pre-trigger history is complete
   assign trig    = hit && (filled_q >= {1'b0, pretrig_q});
   assign post_ld = ADDR_W'(DEPTH - 1) - pretrig_q;
   assign we      = !io_abort && (state_q == S_ARMED || state_q == S_TRIGGERED);

   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      cnt_d     = cnt_q;
      post_d    = post_q;
      pretrig_d = pretrig_q;
      filled_d  = filled_q;
      done_d    = 1'b0;
      if (io_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (io_arm) begin
                  state_d   = S_ARMED;
                  pretrig_d = io_pretrig;
                  wptr_d    = '0;
                  filled_d  = '0;
                  cnt_d     = '0;
               end
            end
            S_ARMED: begin
               wptr_d = wptr_q + 1'b1;
               if (filled_q != (ADDR_W+1)'(DEPTH)) filled_d = filled_q + 1'b1;
               if (trig) begin
                  post_d = post_ld;
                  if (post_ld == '0) begin
                     state_d = S_READOUT;
                     rptr_d  = wptr_q + 1'b1;
                     cnt_d   = '0;
                  end else begin
                     state_d = S_TRIGGERED;
                  end
               end
            end
            S_TRIGGERED: begin
               wptr_d = wptr_q + 1'b1;
               post_d = post_q - 1'b1;
               // After the final post-trigger write the write pointer sits on the oldest sample
               if (post_q == ADDR_W'(1)) begin
                  state_d = S_READOUT;
                  rptr_d  = wptr_q + 1'b1;
                  cnt_d   = '0;
               end
            end
            default: begin
               if (io_out_ready) begin
                  rptr_d = rptr_q + 1'b1;
                  cnt_d  = cnt_q + 1'b1;
                  if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         post_q    <= '0;
         pretrig_q <= '0;
         filled_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         post_q    <= post_d;
         pretrig_q <= pretrig_d;
         filled_q  <= filled_d;
         done_q    <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem_q[wptr_q] <= io_probe;
   end

   assign io_out_valid = (state_q == S_READOUT);
   assign io_out_data  = io_out_valid ? mem_q[rptr_q] : '0;
   assign io_out_last  = io_out_valid && (cnt_q == ADDR_W'(DEPTH - 1));
   assign io_done      = done_q;
   assign io_state     = state_q;
endmodule
